masked_add_sched: RTL and testbench



---
 rtl/masked_add_sched.sv | 181 ++++++++++++++++++
 tb/tb_masked_add_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_add_sched.sv
// masked_add_sched
//   Round-robin scheduler that shares one masked ripple-carry adder (masked_rca)
//   between NREQ requesters. For each operation it:
//     - picks a winner and latches that requester's operands;
//     - advances the adder's entropy seed;
//     - holds the adder inputs stable for SETTLE cycles;
//     - captures the sum and returns it on a valid/ready channel, tagged with
//       the requester ID.
//
//   Optional build macro: MASKED_ADD_SCHED_CHECK_EN
//     When defined, the captured result is compared against a plain
//     (WIDTH+1)-bit sum of the latched operands, and err is set sticky on a
//     mismatch. When undefined, err is tied to 0.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   req_valid/ready     per-requester request handshake (ready is one-hot or 0)
//   req_a, req_b        packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin             per-requester carry-in
//   rsp_valid/ready     response handshake
//   rsp_id              index of the served requester
//   rsp_sum, rsp_cout   captured result
//   seed_load, seed_in  seed reload (honoured only while idle; 0 maps to 1)
//   rca_seed            seed driven to masked_rca
//   rca_a, rca_b        operands driven to masked_rca
//   rca_cin             carry-in driven to masked_rca
//   rca_sum, rca_cout   result returned by masked_rca
//   busy                high whenever an operation is in flight
//   err                 sticky self-check error
module masked_add_sched #(
  parameter int WIDTH   = 8,
  parameter int NSHARES = 3,
  parameter int NREQ    = 4,
  parameter int SETTLE  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NREQ-1:0]                   req_valid,
  output logic [NREQ-1:0]                   req_ready,
  input  logic [NREQ*WIDTH-1:0]             req_a,
  input  logic [NREQ*WIDTH-1:0]             req_b,
  input  logic [NREQ-1:0]                   req_cin,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [$clog2(NREQ)-1:0]           rsp_id,
  output logic [WIDTH-1:0]                  rsp_sum,
  output logic                              rsp_cout,
  input  logic                              seed_load,
  input  logic [(NSHARES-1)*14-1:0]         seed_in,
  output logic [(NSHARES-1)*14-1:0]         rca_seed,
  output logic [WIDTH-1:0]                  rca_a,
  output logic [WIDTH-1:0]                  rca_b,
  output logic                              rca_cin,
  input  logic [WIDTH-1:0]                  rca_sum,
  input  logic                              rca_cout,
  output logic                              busy,
  output logic                              err
);

  localparam int SW  = (NSHARES - 1) * 14;
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RESP
  } state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [SW-1:0]    seed;
  logic [CW-1:0]    cnt;

  logic [NREQ-1:0]  gnt_oh;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_any;
  logic             capture;

  // (base + off) mod NREQ without relying on NREQ being a power of two.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  function automatic logic [SW-1:0] lfsr(input logic [SW-1:0] s);
    return {s[SW-2:0], s[SW-1] ^ s[SW-2] ^ s[0]};
  endfunction

  // First valid requester at or after rr_ptr, scanning upward with wrap.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gnt_oh  = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && req_valid[wrap_add(rr_ptr, k)]) begin
        gnt_oh[wrap_add(rr_ptr, k)] = 1'b1;
        gnt_id                      = wrap_add(rr_ptr, k);
        gnt_any                     = 1'b1;
      end
    end
  end

  // Reset is gated in so no request is accepted on the reset-release edge.
  assign req_ready = (state == ST_IDLE && !rst) ? gnt_oh : '0;
  assign busy      = (state != ST_IDLE);
  assign rca_seed  = seed;
  assign capture   = (state == ST_SETTLE) && (cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      seed      <= SW'(1);
      cnt       <= '0;
      rca_a     <= '0;
      rca_b     <= '0;
      rca_cin   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (seed_load) seed <= (seed_in == '0) ? SW'(1) : seed_in;
          if (gnt_any) begin
            rca_a   <= req_a[gnt_id*WIDTH +: WIDTH];
            rca_b   <= req_b[gnt_id*WIDTH +: WIDTH];
            rca_cin <= req_cin[gnt_id];
            rsp_id  <= gnt_id;
            rr_ptr  <= wrap_add(gnt_id, 1);
            // A seed loaded in the grant cycle is used as-is for this op.
            if (!seed_load) seed <= lfsr(seed);
            cnt     <= CW'(SETTLE - 1);
            state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (capture) begin
            rsp_sum   <= rca_sum;
            rsp_cout  <= rca_cout;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MASKED_ADD_SCHED_CHECK_EN
  logic [WIDTH:0] check_sum;

  assign check_sum = {1'b0, rca_a} + {1'b0, rca_b} + (WIDTH+1)'(rca_cin);

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (capture && (check_sum != {rca_cout, rca_sum})) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_masked_add_sched.sv
// tb_masked_add_sched
//   Directed bench for masked_add_sched (WIDTH=8, NSHARES=3, NREQ=4, SETTLE=2).
//   A behavioural adder stands in for masked_rca; 'fault' skews its sum by +1.
module tb_masked_add_sched;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int SW    = 28;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic                  seed_load;
  logic [SW-1:0]         seed_in;
  logic [SW-1:0]         rca_seed;
  logic [WIDTH-1:0]      rca_a;
  logic [WIDTH-1:0]      rca_b;
  logic                  rca_cin;
  logic [WIDTH-1:0]      rca_sum;
  logic                  rca_cout;
  logic                  busy;
  logic                  err;
  logic                  fault;

  int checks = 0;
  int errors = 0;

`ifdef MASKED_ADD_SCHED_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  masked_add_sched #(.WIDTH(8), .NSHARES(3), .NREQ(4), .SETTLE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .rca_seed  (rca_seed),
    .rca_a     (rca_a),
    .rca_b     (rca_b),
    .rca_cin   (rca_cin),
    .rca_sum   (rca_sum),
    .rca_cout  (rca_cout),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  assign {rca_cout, rca_sum} = {1'b0, rca_a} + {1'b0, rca_b} + 9'(rca_cin) + 9'(fault);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic cin);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_cin[i]              = cin;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
    rsp_ready = 1'b1; seed_load = 1'b0; seed_in = '0; fault = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // Single request from requester 2: 200 + 100 + 1 = 301 -> sum 45, cout 1.
    set_req(2, 8'd200, 8'd100, 1'b1);
    req_valid = 4'b0100;
    #1;
    check("grant_r2", req_ready, 4'b0100);
    check("idle_busy", busy, 1'b0);
    tick();                                   // edge T
    req_valid = '0;
    check("lat_a", rca_a, 8'd200);
    check("lat_b", rca_b, 8'd100);
    check("lat_cin", rca_cin, 1'b1);
    check("seed_adv1", rca_seed, 28'h3);
    check("busy_settle", busy, 1'b1);
    check("no_rsp_T", rsp_valid, 1'b0);
    tick();                                   // T+1
    check("no_rsp_T1", rsp_valid, 1'b0);
    tick();                                   // T+2
    check("rsp_valid_T2", rsp_valid, 1'b1);
    check("rsp_sum_45", rsp_sum, 8'd45);
    check("rsp_cout_1", rsp_cout, 1'b1);
    check("rsp_id_2", rsp_id, 2'd2);
    tick();
    check("rsp_drop", rsp_valid, 1'b0);
    check("back_idle", busy, 1'b0);

    // Reset mid-SETTLE with requests pending; pointer is 3, only 1 valid.
    set_req(1, 8'd5, 8'd6, 1'b0);
    set_req(0, 8'd15, 8'd27, 1'b0);
    set_req(3, 8'd255, 8'd1, 1'b0);
    req_valid = 4'b0010;
    #1;
    check("grant_r1", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1001;
    tick();
    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 2'd0);
    check("rst_rsp_sum", rsp_sum, 8'd0);
    check("rst_rsp_cout", rsp_cout, 1'b0);
    check("rst_rca_a", rca_a, 8'd0);
    check("rst_rca_b", rca_b, 8'd0);
    check("rst_rca_cin", rca_cin, 1'b0);
    check("rst_seed", rca_seed, 28'h1);
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_grant0", req_ready, 4'b0001);

    // Requesters 0 and 3 both pending: 0 (15+27=42) then 3 (255+1=256).
    tick();                                   // accept 0
    check("rr0_a", rca_a, 8'd15);
    check("rr0_seed", rca_seed, 28'h3);
    repeat (2) tick();
    check("rr0_valid", rsp_valid, 1'b1);
    check("rr0_sum", rsp_sum, 8'd42);
    check("rr0_cout", rsp_cout, 1'b0);
    check("rr0_id", rsp_id, 2'd0);
    tick();
    #1;
    check("rr_grant3", req_ready, 4'b1000);
    tick();                                   // accept 3, four cycles after 0
    check("rr3_a", rca_a, 8'd255);
    check("rr3_seed", rca_seed, 28'h7);
    repeat (2) tick();
    check("rr3_valid", rsp_valid, 1'b1);
    check("rr3_sum", rsp_sum, 8'd0);
    check("rr3_cout", rsp_cout, 1'b1);
    check("rr3_id", rsp_id, 2'd3);
    tick();
    set_req(0, 8'd10, 8'd20, 1'b1);
    rsp_ready = 1'b0;
    #1;
    check("rr_wrap_grant0", req_ready, 4'b0001);

    // Backpressure: 10 + 20 + 1 = 31, held for 5 cycles.
    tick();
    check("bp_seed", rca_seed, 28'hF);
    repeat (2) tick();
    check("bp_valid", rsp_valid, 1'b1);
    check("bp_sum", rsp_sum, 8'd31);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", rsp_valid, 1'b1);
      check("bp_hold_sum", rsp_sum, 8'd31);
      check("bp_hold_id", rsp_id, 2'd0);
      check("bp_hold_ready", req_ready, 4'b0000);
      check("bp_hold_busy", busy, 1'b1);
    end
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    check("bp_release_valid", rsp_valid, 1'b0);
    check("bp_release_idle", busy, 1'b0);
    check("bp_retain_sum", rsp_sum, 8'd31);

    // Seed loading: zero maps to 1; load with grant is used unadvanced.
    seed_load = 1'b1;
    seed_in   = '0;
    tick();
    seed_load = 1'b0;
    check("seed_zero", rca_seed, 28'h1);
    seed_load = 1'b1;
    seed_in   = 28'h5A5A5A5;
    set_req(1, 8'd1, 8'd2, 1'b0);
    req_valid = 4'b0010;
    tick();                                   // edge T
    seed_load = 1'b0;
    req_valid = '0;
    check("seed_with_grant", rca_seed, 28'h5A5A5A5);
    check("seed_grant_busy", busy, 1'b1);
    seed_load = 1'b1;
    seed_in   = 28'h1234567;
    tick();                                   // T+1, load ignored
    seed_load = 1'b0;
    check("seed_ignored", rca_seed, 28'h5A5A5A5);
    tick();                                   // T+2
    check("seed_op_valid", rsp_valid, 1'b1);
    check("seed_op_sum", rsp_sum, 8'd3);
    check("seed_op_id", rsp_id, 2'd1);
    tick();
    check("seed_after", rca_seed, 28'h5A5A5A5);

    // Adder fault: 3 + 4 reported as 8; response passes through unchanged.
    fault = 1'b1;
    set_req(2, 8'd3, 8'd4, 1'b0);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    check("fault_err_pre", err, 1'b0);
    repeat (2) tick();
    fault = 1'b0;
    check("fault_valid", rsp_valid, 1'b1);
    check("fault_sum", rsp_sum, 8'd8);
    check("fault_id", rsp_id, 2'd2);
    check("fault_err", err, EXP_ERR);
    repeat (2) tick();
    check("fault_err_sticky", err, EXP_ERR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
